cpu_seq_ctrl: RTL and testbench

- Multi-cycle control sequencer for the 4-bit CPU.
- Drives the program counter's set_pc (zero) and the clock-enable pulse that advances it. Handshakes instruction fetch with instruction memory and issues ALU and register-file strobes per 9-bit instruction.
- Sits between instruction memory, the PC block, the ALU and the register file. It is the only source of PC advance and PC reset.

---
 rtl/cpu_seq_ctrl_pkg.sv | 39 +++
 rtl/cpu_seq_ctrl_seq_timer.sv | 39 +++
 rtl/cpu_seq_ctrl.sv | 166 ++++++++++++++++
 tb/tb_cpu_seq_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_seq_ctrl_pkg.sv
// cpu_seq_ctrl_pkg
//   Shared definitions for the 4-bit CPU control sequencer:
//   opcode constants, FSM state encoding, default timing values and
//   a helper that classifies ALU opcodes.
//   Optional feature macro used by the sequencer: CPU_SEQ_SINGLE_STEP_EN.
package cpu_seq_ctrl_pkg;

   // Opcodes live in INS[8:6]
   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_LDI  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_OR   = 3'b101;
   localparam logic [2:0] OP_HALT = 3'b110;
   localparam logic [2:0] OP_JMP  = 3'b111;

   // Default timing values
   localparam int DEF_RST_HOLD      = 3;  // set_pc cycles after reset release (2..15)
   localparam int DEF_FETCH_TIMEOUT = 8;  // FETCH cycles before FAULT (1..15)
   localparam int DEF_TMO_W         = 4;  // timer width

   typedef enum logic [2:0] {
      ST_RST,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_WB,
      ST_HLT,
      ST_FAULT,
      ST_STEP_WAIT
   } state_t;

   // LDI/ADD/SUB/AND/OR take the EXEC -> WB path
   function automatic logic is_alu_op(input logic [2:0] opc);
      return (opc >= OP_LDI) && (opc <= OP_OR);
   endfunction

endpackage

// File: rtl/cpu_seq_ctrl_seq_timer.sv
// cpu_seq_ctrl_seq_timer
//   Loadable down-counter with a terminal flag. Shared by the reset-hold
//   and fetch-timeout phases of the sequencer. Load has priority over
//   decrement; decrement saturates at zero.
// Ports:
//   i_clk       clock, rising edge
//   i_rst_n     asynchronous active-low reset (count -> 0)
//   i_load      load i_load_val on next edge
//   i_load_val  value to load
//   i_dec       decrement on next edge
//   o_tc        terminal flag, count == 0
module cpu_seq_ctrl_seq_timer
   import cpu_seq_ctrl_pkg::*;
#(
   parameter int W = DEF_TMO_W
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_dec,
   output logic         o_tc
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl
//   Multi-cycle control sequencer for the 4-bit CPU. Holds the PC at zero
//   after reset, handshakes instruction fetch, and issues ALU / register-file
//   strobes and the PC advance pulse for each 9-bit instruction.
//   Optional macro CPU_SEQ_SINGLE_STEP_EN adds i_step: after every PC advance
//   the FSM parks in STEP_WAIT (halted) until i_step is seen.
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_ins        instruction word, valid while i_imem_ack=1
//   i_imem_ack   instruction memory data valid
//   i_step       (CPU_SEQ_SINGLE_STEP_EN only) single-step advance
//   i_run        resume pulse from HALT
//   o_imem_req   fetch request (FETCH only)
//   o_set_pc     force PC to zero on next edge
//   o_pc_step    PC advance enable
//   o_alu_en     ALU operate strobe
//   o_reg_we     register-file write enable
//   o_opc        latched opcode
//   o_halted     high while halted (or parked in STEP_WAIT)
//   o_fault      sticky fetch-timeout flag
module cpu_seq_ctrl
   import cpu_seq_ctrl_pkg::*;
#(
   parameter int RST_HOLD      = DEF_RST_HOLD,
   parameter int FETCH_TIMEOUT = DEF_FETCH_TIMEOUT,
   parameter int TMO_W         = DEF_TMO_W
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [8:0] i_ins,
   input  logic       i_imem_ack,
`ifdef CPU_SEQ_SINGLE_STEP_EN
   input  logic       i_step,
`endif
   input  logic       i_run,
   output logic       o_imem_req,
   output logic       o_set_pc,
   output logic       o_pc_step,
   output logic       o_alu_en,
   output logic       o_reg_we,
   output logic [2:0] o_opc,
   output logic       o_halted,
   output logic       o_fault
);

   // The first RST cycle arms the timer, so the load value is two short
   // of the number of set_pc edges wanted.
   localparam logic [TMO_W-1:0] L_HOLD_LOAD  = TMO_W'(RST_HOLD - 2);
   localparam logic [TMO_W-1:0] L_FETCH_LOAD = TMO_W'(FETCH_TIMEOUT - 1);

   state_t     r_state;
   state_t     w_state_next;
   state_t     w_after_step;
   logic       r_armed;
   logic       r_imem_req, r_set_pc, r_pc_step, r_alu_en, r_reg_we;
   logic       r_halted, r_fault;
   logic [2:0] r_opc;
   logic       w_tmr_load, w_tmr_dec, w_tmr_tc;
   logic [TMO_W-1:0] w_tmr_val;
   logic       w_resume;
   logic       w_ins_unused;

   // Operand bits INS[5:0] are consumed by the PC block and datapath.
   assign w_ins_unused = ^i_ins[5:0];

`ifdef CPU_SEQ_SINGLE_STEP_EN
   assign w_after_step = ST_STEP_WAIT;
   assign w_resume     = i_run | i_step;
`else
   assign w_after_step = ST_FETCH;
   assign w_resume     = i_run;
`endif

   cpu_seq_ctrl_seq_timer #(.W(TMO_W)) u_timer (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_load     (w_tmr_load),
      .i_load_val (w_tmr_val),
      .i_dec      (w_tmr_dec),
      .o_tc       (w_tmr_tc)
   );

   always_comb begin
      w_state_next = r_state;
      w_tmr_load   = 1'b0;
      w_tmr_val    = '0;
      w_tmr_dec    = 1'b0;
      case (r_state)
         ST_RST: begin
            if (!r_armed) begin
               w_tmr_load = 1'b1;
               w_tmr_val  = L_HOLD_LOAD;
            end else if (w_tmr_tc) begin
               w_state_next = ST_FETCH;
            end else begin
               w_tmr_dec = 1'b1;
            end
         end
         ST_FETCH: begin
            // ack wins over the timeout in the same cycle
            if (i_imem_ack)    w_state_next = ST_DECODE;
            else if (w_tmr_tc) w_state_next = ST_FAULT;
            else               w_tmr_dec    = 1'b1;
         end
         ST_DECODE: w_state_next = (r_opc == OP_HALT) ? ST_HLT : ST_EXEC;
         ST_EXEC:   w_state_next = is_alu_op(r_opc) ? ST_WB : w_after_step;
         ST_WB:     w_state_next = w_after_step;
         ST_HLT:    if (w_resume) w_state_next = w_after_step;
`ifdef CPU_SEQ_SINGLE_STEP_EN
         ST_STEP_WAIT: if (i_step) w_state_next = ST_FETCH;
`else
         ST_STEP_WAIT: w_state_next = ST_FETCH;
`endif
         ST_FAULT:  w_state_next = ST_FAULT;
         default:   w_state_next = ST_RST;
      endcase
      // Every entry into FETCH restarts the timeout window.
      if ((w_state_next == ST_FETCH) && (r_state != ST_FETCH)) begin
         w_tmr_load = 1'b1;
         w_tmr_val  = L_FETCH_LOAD;
      end
   end

   // State and all strobes registered from the next state.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= ST_RST;
         r_armed    <= 1'b0;
         r_set_pc   <= 1'b1;
         r_imem_req <= 1'b0;
         r_pc_step  <= 1'b0;
         r_alu_en   <= 1'b0;
         r_reg_we   <= 1'b0;
         r_halted   <= 1'b0;
         r_fault    <= 1'b0;
         r_opc      <= 3'b000;
      end else begin
         r_state    <= w_state_next;
         r_armed    <= 1'b1;
         r_set_pc   <= (w_state_next == ST_RST);
         r_imem_req <= (w_state_next == ST_FETCH);
         r_alu_en   <= (w_state_next == ST_EXEC) && is_alu_op(r_opc);
         r_pc_step  <= ((w_state_next == ST_EXEC) && !is_alu_op(r_opc)) ||
                       (w_state_next == ST_WB);
         r_reg_we   <= (w_state_next == ST_WB);
         r_halted   <= (w_state_next == ST_HLT) || (w_state_next == ST_STEP_WAIT);
         r_fault    <= r_fault || (w_state_next == ST_FAULT);
         if ((r_state == ST_FETCH) && i_imem_ack) begin
            r_opc <= i_ins[8:6];
         end
      end
   end

   assign o_imem_req = r_imem_req;
   assign o_set_pc   = r_set_pc;
   // Resume from HALT advances the PC in the very cycle run is seen, so
   // that term bypasses the output register.
   assign o_pc_step  = r_pc_step || ((r_state == ST_HLT) && w_resume);
   assign o_alu_en   = r_alu_en;
   assign o_reg_we   = r_reg_we;
   assign o_opc      = r_opc;
   assign o_halted   = r_halted;
   assign o_fault    = r_fault;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// tb_cpu_seq_ctrl
//   Directed, table-driven bench for cpu_seq_ctrl. Outputs are compared as
//   the vector {set_pc, imem_req, pc_step, alu_en, reg_we, halted, fault}.
module tb_cpu_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [8:0] ins;
   logic       imem_ack;
   logic       run;
`ifdef CPU_SEQ_SINGLE_STEP_EN
   logic       step;
`endif
   logic       imem_req, set_pc, pc_step, alu_en, reg_we, halted, fault;
   logic [2:0] opc;
   logic [6:0] outs;

   int n_cmp = 0;
   int n_bad = 0;

   localparam logic [6:0] V_IDLE  = 7'b0000000;
   localparam logic [6:0] V_RST   = 7'b1000000;
   localparam logic [6:0] V_FETCH = 7'b0100000;
   localparam logic [6:0] V_STEP  = 7'b0010000;
   localparam logic [6:0] V_ALU   = 7'b0001000;
   localparam logic [6:0] V_WB    = 7'b0010100;
   localparam logic [6:0] V_HALT  = 7'b0000010;
   localparam logic [6:0] V_RUN   = 7'b0010010;
   localparam logic [6:0] V_FAULT = 7'b0000001;

   always #5 clk = ~clk;

   assign outs = {set_pc, imem_req, pc_step, alu_en, reg_we, halted, fault};

   cpu_seq_ctrl dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_ins      (ins),
      .i_imem_ack (imem_ack),
`ifdef CPU_SEQ_SINGLE_STEP_EN
      .i_step     (step),
`endif
      .i_run      (run),
      .o_imem_req (imem_req),
      .o_set_pc   (set_pc),
      .o_pc_step  (pc_step),
      .o_alu_en   (alu_en),
      .o_reg_we   (reg_we),
      .o_opc      (opc),
      .o_halted   (halted),
      .o_fault    (fault)
   );

   typedef struct {
      logic [8:0] ins;
      logic [2:0] opc;
      logic       alu;
      logic [6:0] exec_exp;
   } vec_t;

   vec_t vecs [7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [6:0] exp);
      n_cmp++;
      if (outs !== exp) begin
         n_bad++;
         $display("FAIL %s: outputs %b, expected %b", nm, outs, exp);
      end else begin
         $display("ok   %s: outputs %b", nm, outs);
      end
   endtask

   task automatic chk_val(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end else begin
         $display("ok   %s: %0d", nm, act);
      end
   endtask

   // Called in the cycle carrying the instruction's pc_step; ends with the
   // next fetch visible.
   task automatic finish_instr(input string nm);
      tick();
      run = 1'b0;
`ifdef CPU_SEQ_SINGLE_STEP_EN
      chk({nm, "_stepwait"}, V_HALT);
      tick();
      chk({nm, "_stepwait2"}, V_HALT);
      step = 1'b1;
      tick();
      step = 1'b0;
`endif
      chk({nm, "_refetch"}, V_FETCH);
   endtask

   task automatic reset_and_hold(input string nm);
      int cyc;
      rst_n = 1'b0;
      #1;
      chk({nm, "_async"}, V_RST);
      tick();
      tick();
      chk_val({nm, "_opc"}, int'(opc), 0);
      rst_n = 1'b1;
      cyc = 0;
      while (!imem_req && cyc < 20) begin
         if (pc_step) chk({nm, "_no_step_in_hold"}, V_RST);
         tick();
         cyc++;
      end
      chk_val({nm, "_hold_cycles"}, cyc, 3);
      chk({nm, "_fetch"}, V_FETCH);
   endtask

   initial begin
      vecs[0] = '{9'b000_00_0000, 3'b000, 1'b0, V_STEP};
      vecs[1] = '{9'b001_01_1010, 3'b001, 1'b1, V_ALU};
      vecs[2] = '{9'b010_00_0011, 3'b010, 1'b1, V_ALU};
      vecs[3] = '{9'b011_11_0101, 3'b011, 1'b1, V_ALU};
      vecs[4] = '{9'b100_10_1100, 3'b100, 1'b1, V_ALU};
      vecs[5] = '{9'b101_01_0110, 3'b101, 1'b1, V_ALU};
      vecs[6] = '{9'b111_10_0000, 3'b111, 1'b0, V_STEP};

      rst_n = 1'b1; ins = '0; imem_ack = 1'b0; run = 1'b0;
`ifdef CPU_SEQ_SINGLE_STEP_EN
      step = 1'b0;
`endif
      #1;
      // Reset hold: set_pc sampled high at 3 edges after release
      rst_n = 1'b0;
      #1;
      chk("reset_state", V_RST);
      tick();
      tick();
      chk("reset_held", V_RST);
      rst_n = 1'b1;
      chk("hold_c1", V_RST);
      tick(); chk("hold_c2", V_RST);
      tick(); chk("hold_c3", V_RST);
      tick(); chk("hold_fetch_c4", V_FETCH);

      // Table: every instruction class, ack on the first FETCH cycle
      for (int i = 0; i < 7; i++) begin
         ins = vecs[i].ins;
         imem_ack = 1'b1;
         tick();
         imem_ack = 1'b0;
         chk($sformatf("v%0d_decode", i), V_IDLE);
         chk_val($sformatf("v%0d_opc", i), int'(opc), int'(vecs[i].opc));
         tick();
         chk($sformatf("v%0d_exec", i), vecs[i].exec_exp);
         if (vecs[i].alu) begin
            tick();
            chk($sformatf("v%0d_wb", i), V_WB);
         end
         finish_instr($sformatf("v%0d", i));
      end

      // HALT then resume with run five cycles later
      ins = 9'b110_00_0000;
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      chk("halt_decode", V_IDLE);
      chk_val("halt_opc", int'(opc), 6);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk($sformatf("halt_wait%0d", k), V_HALT);
      end
      run = 1'b1;
      #1;
      chk("halt_run_step", V_RUN);
      finish_instr("halt_resume");

      // Late ack on the 8th FETCH cycle; run ignored outside HLT
      run = 1'b1;
      for (int k = 1; k < 8; k++) begin
         tick();
         chk($sformatf("late_wait%0d", k), V_FETCH);
      end
      ins = 9'b000_00_0000;
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      run = 1'b0;
      chk("late_ack_decode", V_IDLE);
      tick();
      chk("late_ack_exec", V_STEP);
      finish_instr("late_ack");

      // Asynchronous reset during WB
      ins = 9'b010_00_0011;
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      tick();
      chk("midwb_exec", V_ALU);
      tick();
      chk("midwb_wb", V_WB);
      #2;
      reset_and_hold("midwb_rst");

      // Fetch timeout: no ack for 8 cycles
      for (int k = 1; k < 8; k++) begin
         tick();
         chk($sformatf("tmo_wait%0d", k), V_FETCH);
      end
      tick();
      chk("tmo_fault", V_FAULT);
      imem_ack = 1'b1;
      run = 1'b1;
      tick(); tick(); tick();
      chk("tmo_sticky", V_FAULT);
      imem_ack = 1'b0;
      run = 1'b0;
      #2;
      reset_and_hold("fault_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Global guard so the run always ends
   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
